dmem_requester: RTL and testbench

- Initiator side of the data-memory interface for the memory stage.
- Accepts the CPU's per-instruction load/store request (mem_read, mem_write, address, write data) and drives a multi-cycle, req/ack-handshaked data memory.
- Stalls the pipeline until the access completes, returns load data, and flags misaligned, conflicting or timed-out accesses.

---
 rtl/dmem_requester.sv | 157 +++++++++++++++
 tb/tb_dmem_requester.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_requester.sv
// rtl/dmem_requester.sv - data-memory initiator for the memory stage
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   cpu_mem_read      load request from the memory stage
//   cpu_mem_write     store request from the memory stage
//   cpu_address       byte address, must be 8-byte aligned
//   cpu_write_data    store data
//   stall             combinational pipeline hold
//   cpu_read_data     registered load result
//   cpu_read_valid    one-cycle pulse when a load updates cpu_read_data
//   error             one-cycle pulse on misaligned, conflicting or timed-out access
//   mem_req/mem_we    registered request and write-enable to data memory
//   mem_addr/mem_wdata registered address and write data to data memory
//   mem_ack/mem_rdata memory completion strobe and read data
//   access_count      saturating count of successful accesses
module dmem_requester #(
  parameter int WORD           = 64,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_mem_read,
  input  logic             cpu_mem_write,
  input  logic [WORD-1:0]  cpu_address,
  input  logic [WORD-1:0]  cpu_write_data,
  output logic             stall,
  output logic [WORD-1:0]  cpu_read_data,
  output logic             cpu_read_valid,
  output logic             error,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WORD-1:0]  mem_addr,
  output logic [WORD-1:0]  mem_wdata,
  input  logic             mem_ack,
  input  logic [WORD-1:0]  mem_rdata,
  output logic [CNT_W-1:0] access_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] tcnt;

  logic req_any;
  logic legal;
  logic bad;
  logic timed_out;

  // A legal request is exactly one of read/write with an 8-byte aligned
  // address; anything else that asserts a request line is flagged.
  assign req_any   = cpu_mem_read | cpu_mem_write;
  assign legal     = (cpu_mem_read ^ cpu_mem_write) && (cpu_address[2:0] == 3'b000);
  assign bad       = req_any && !legal;
  assign timed_out = (tcnt == T_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          stall      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem_ack || timed_out) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Request inputs seen here belong to the instruction just completed.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      cpu_read_data  <= '0;
      cpu_read_valid <= 1'b0;
      error          <= 1'b0;
      access_count   <= '0;
      tcnt           <= '0;
    end else begin
      cpu_read_valid <= 1'b0;
      error          <= 1'b0;
      case (state)
        IDLE: begin
          if (legal) begin
            mem_req   <= 1'b1;
            mem_we    <= cpu_mem_write;
            mem_addr  <= cpu_address;
            mem_wdata <= cpu_write_data;
            tcnt      <= '0;
          end else if (bad) begin
            error <= 1'b1;
          end
        end
        ACCESS: begin
          // An ack in the final allowed cycle wins over the timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              cpu_read_data  <= mem_rdata;
              cpu_read_valid <= 1'b1;
            end
            if (access_count != '1) begin
              access_count <= access_count + CNT_W'(1);
            end
          end else if (timed_out) begin
            mem_req <= 1'b0;
            error   <= 1'b1;
            if (!mem_we) begin
              cpu_read_data <= '0;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DONE: begin
          mem_req <= 1'b0;
        end
        default: begin
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_requester.sv
// tb/tb_dmem_requester.sv - directed self-checking bench for dmem_requester
module tb_dmem_requester;

  localparam int WORD = 64;
  localparam int TOUT = 16;
  localparam int CW   = 32;

  localparam logic [63:0] NEG168 = -64'sd168;

  logic            clk;
  logic            reset;
  logic            cpu_mem_read;
  logic            cpu_mem_write;
  logic [WORD-1:0] cpu_address;
  logic [WORD-1:0] cpu_write_data;
  logic            stall;
  logic [WORD-1:0] cpu_read_data;
  logic            cpu_read_valid;
  logic            error;
  logic            mem_req;
  logic            mem_we;
  logic [WORD-1:0] mem_addr;
  logic [WORD-1:0] mem_wdata;
  logic            mem_ack;
  logic [WORD-1:0] mem_rdata;
  logic [CW-1:0]   access_count;

  int n_checks;
  int n_fails;

  dmem_requester #(
    .WORD(WORD),
    .TIMEOUT_CYCLES(TOUT),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu_mem_read(cpu_mem_read),
    .cpu_mem_write(cpu_mem_write),
    .cpu_address(cpu_address),
    .cpu_write_data(cpu_write_data),
    .stall(stall),
    .cpu_read_data(cpu_read_data),
    .cpu_read_valid(cpu_read_valid),
    .error(error),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .access_count(access_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs applied afterwards settle before checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d);
    cpu_mem_read   = rd;
    cpu_mem_write  = wr;
    cpu_address    = a;
    cpu_write_data = d;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b1;
    mem_ack  = 1'b0;
    mem_rdata = '0;
    set_req(1'b0, 1'b0, 64'd0, 64'd0);

    // 1. reset for two cycles, then idle
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_rdata", cpu_read_data, 64'd0);
    chk("rst_count", {32'd0, access_count}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    tick();
    chk("idle_stall", {63'd0, stall}, 64'd0);
    chk("idle_mem_req", {63'd0, mem_req}, 64'd0);

    // 2. store @16, ack on the 3rd ACCESS cycle
    set_req(1'b0, 1'b1, 64'd16, NEG168);
    #1;
    chk("st_c0_stall", {63'd0, stall}, 64'd1);
    chk("st_c0_req", {63'd0, mem_req}, 64'd0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) mem_ack = 1'b1;
      #1;
      chk("st_stall", {63'd0, stall}, 64'd1);
      chk("st_req", {63'd0, mem_req}, 64'd1);
      chk("st_we", {63'd0, mem_we}, 64'd1);
      chk("st_addr", mem_addr, 64'd16);
      chk("st_wdata", mem_wdata, NEG168);
    end
    tick();
    mem_ack = 1'b0;
    #1;
    chk("st_done_stall", {63'd0, stall}, 64'd0);
    chk("st_done_req", {63'd0, mem_req}, 64'd0);
    chk("st_done_count", {32'd0, access_count}, 64'd1);
    chk("st_done_valid", {63'd0, cpu_read_valid}, 64'd0);
    chk("st_done_rdata", cpu_read_data, 64'd0);
    tick();
    set_req(1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk("st_no_reissue_req", {63'd0, mem_req}, 64'd0);
    chk("st_after_stall", {63'd0, stall}, 64'd0);

    // 3. load @16, ack in the first ACCESS cycle
    set_req(1'b1, 1'b0, 64'd16, 64'd0);
    #1;
    chk("ld_c0_stall", {63'd0, stall}, 64'd1);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = NEG168;
    #1;
    chk("ld_c1_stall", {63'd0, stall}, 64'd1);
    chk("ld_c1_req", {63'd0, mem_req}, 64'd1);
    chk("ld_c1_we", {63'd0, mem_we}, 64'd0);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 64'hDEAD_BEEF;
    #1;
    chk("ld_done_stall", {63'd0, stall}, 64'd0);
    chk("ld_done_rdata", cpu_read_data, NEG168);
    chk("ld_done_valid", {63'd0, cpu_read_valid}, 64'd1);
    chk("ld_done_error", {63'd0, error}, 64'd0);
    chk("ld_done_count", {32'd0, access_count}, 64'd2);
    tick();
    set_req(1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk("ld_after_valid", {63'd0, cpu_read_valid}, 64'd0);
    chk("ld_after_rdata", cpu_read_data, NEG168);

    // 4. misaligned load, then read+write conflict
    set_req(1'b1, 1'b0, 64'd20, 64'd0);
    #1;
    chk("mis_stall", {63'd0, stall}, 64'd0);
    tick();
    set_req(1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk("mis_error", {63'd0, error}, 64'd1);
    chk("mis_req", {63'd0, mem_req}, 64'd0);
    tick();
    chk("mis_error_clr", {63'd0, error}, 64'd0);
    set_req(1'b1, 1'b1, 64'd64, 64'd7);
    #1;
    chk("cf_stall", {63'd0, stall}, 64'd0);
    tick();
    set_req(1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk("cf_error", {63'd0, error}, 64'd1);
    chk("cf_req", {63'd0, mem_req}, 64'd0);
    chk("cf_count", {32'd0, access_count}, 64'd2);
    tick();
    chk("cf_error_clr", {63'd0, error}, 64'd0);

    // 5. load @64, memory never acks
    set_req(1'b1, 1'b0, 64'd64, 64'd0);
    #1;
    chk("to_c0_stall", {63'd0, stall}, 64'd1);
    for (int c = 1; c <= TOUT; c++) begin
      tick();
      chk("to_req", {63'd0, mem_req}, 64'd1);
      chk("to_stall", {63'd0, stall}, 64'd1);
      chk("to_error_early", {63'd0, error}, 64'd0);
    end
    tick();
    chk("to_done_req", {63'd0, mem_req}, 64'd0);
    chk("to_done_stall", {63'd0, stall}, 64'd0);
    chk("to_done_error", {63'd0, error}, 64'd1);
    chk("to_done_rdata", cpu_read_data, 64'd0);
    chk("to_done_valid", {63'd0, cpu_read_valid}, 64'd0);
    chk("to_done_count", {32'd0, access_count}, 64'd2);
    tick();
    set_req(1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk("to_after_error", {63'd0, error}, 64'd0);
    chk("to_after_req", {63'd0, mem_req}, 64'd0);

    // 6. store @64, reset on the 2nd ACCESS cycle, ack one cycle later
    set_req(1'b0, 1'b1, 64'd64, 64'd12345);
    #1;
    chk("rs_c0_stall", {63'd0, stall}, 64'd1);
    tick();
    chk("rs_c1_req", {63'd0, mem_req}, 64'd1);
    tick();
    reset = 1'b1;
    #1;
    chk("rs_c2_req", {63'd0, mem_req}, 64'd1);
    tick();
    reset   = 1'b0;
    mem_ack = 1'b1;
    set_req(1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    chk("rs_req_cleared", {63'd0, mem_req}, 64'd0);
    chk("rs_stall", {63'd0, stall}, 64'd0);
    chk("rs_count", {32'd0, access_count}, 64'd0);
    chk("rs_addr", mem_addr, 64'd0);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("rs_ack_ign_req", {63'd0, mem_req}, 64'd0);
    chk("rs_ack_ign_count", {32'd0, access_count}, 64'd0);
    chk("rs_ack_ign_stall", {63'd0, stall}, 64'd0);
    chk("rs_ack_ign_valid", {63'd0, cpu_read_valid}, 64'd0);
    chk("rs_ack_ign_error", {63'd0, error}, 64'd0);
    tick();
    chk("rs_idle_req", {63'd0, mem_req}, 64'd0);
    chk("rs_idle_stall", {63'd0, stall}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
